id_redirect_unit: RTL and testbench
===================================

ID_REDIRECT_UNIT -- requirements
Module: id_redirect_unit

Interface
REQ-001 SHALL have ports clk in 1 (clock, all state updates on rising edge) and rst in 1 (reset, synchronous, active-high).
REQ-002 SHALL have if_pc in 32 (fetch PC) and if_instruction in 32 (fetched instruction word).
REQ-003 SHALL have rs_addr out 5 and rt_addr out 5 (register-file read addresses: id_instruction[25:21], [20:16]), and rs_data in 32 and rt_data in 32 (register-file read data).
REQ-004 SHALL have ex_reg_write in 1, ex_mem_read in 1 and ex_rd in 5 (ID/EX destination info).
REQ-005 SHALL have mem_reg_write in 1, mem_mem_read in 1, mem_rd in 5 and mem_result in 32 (EX/MEM destination info and ALU result).
REQ-006 SHALL have stall out 1, branch_taken out 1, jump_taken out 1, branch_offset out 32 (sign-extended word offset) and new_addr out 32 (word address) as fetch-control outputs.
REQ-007 SHALL have id_pc out 32, id_instruction out 32 and id_valid out 1 (IF/ID register contents).
REQ-008 SHALL have stall_count out 16 and flush_count out 16 (saturating event counters).

Function
REQ-009 SHALL update the IF/ID register on each rising edge with priority rst > stall (hold) > redirect (flush: id_valid=0, id_instruction=0, id_pc=if_pc) > load (id_pc=if_pc, id_instruction=if_instruction, id_valid=1).
REQ-010 SHALL take redirect = branch_taken | jump_taken.
REQ-011 SHALL decode from id_instruction: opcode [31:26], funct [5:0]; BEQ=000100, BNE=000101, J=000010, JAL=000011, JR = opcode 000000 with funct 001000.
REQ-012 SHALL define rs as a source for BEQ/BNE/JR, rt as a source for BEQ/BNE only, and treat register 0 as never matching any dependency.
REQ-013 SHALL forward operands: when mem_reg_write=1, mem_mem_read=0, mem_rd!=0 and mem_rd equals the source, the operand SHALL be mem_result; otherwise it SHALL be rs_data/rt_data.
REQ-014 SHALL assert stall combinationally when id_valid=1 and any of the following holds: (a) ex_mem_read=1 and ex_rd matches rs or rt of any instruction (load-use); (b) the instruction is BEQ/BNE/JR and ex_reg_write=1 and ex_rd matches a source; (c) the instruction is BEQ/BNE/JR and mem_mem_read=1 and mem_rd matches a source.
REQ-015 SHALL hold stall high for as many consecutive cycles as its condition persists (a load feeding a branch gives 2 stall cycles).
REQ-016 SHALL drive branch_taken=1 only when id_valid=1, stall=0, and either the instruction is BEQ with operands equal or BNE with operands unequal.
REQ-017 SHALL drive jump_taken=1 only when id_valid=1, stall=0 and the instruction is J, JAL or JR.
REQ-018 SHALL drive branch_offset = sign-extended id_instruction[15:0]; fetch then adds offset<<2 to PC (= branch PC+4), so there is no delay slot.
REQ-019 SHALL drive new_addr = {2'b00, id_pc[31:28]+carry from id_pc+4, id_instruction[25:0]} for J/JAL, and new_addr = forwarded rs >> 2 for JR.
REQ-020 SHALL give jump_taken priority over branch_taken; the two are mutually exclusive by decode.
REQ-021 SHALL keep the instruction fetched in the same cycle as a redirect out of execution (flushed per REQ-009); a redirect is never raised during stall.
REQ-022 SHALL increment stall_count on each cycle with stall=1 and flush_count on each cycle with redirect=1, each saturating at 0xFFFF.

Reset
REQ-023 SHALL, while rst=1 at an edge, set id_pc=0, id_instruction=0, id_valid=0, stall_count=0 and flush_count=0, so that stall, branch_taken and jump_taken are 0 in the following cycle.
REQ-024 SHALL discard any pending stall or redirect when reset is asserted mid-operation; first load is the if_pc=0 instruction on the first edge after rst deasserts.

Verification
REQ-025 SHALL pass: BEQ $1,$2,+3 at id_pc=0x10 with rs_data=rt_data=5 and no hazards -> branch_taken=1, branch_offset=3, next edge id_valid=0, flush_count=1.
REQ-026 SHALL pass: LW to $3 in EX (ex_mem_read=1, ex_rd=3) while ADD uses $3 in ID -> stall=1 for 1 cycle, id_instruction held, stall_count=1.
REQ-027 SHALL pass: LW $4 in EX, then BNE $4,$0 in ID -> stall 2 cycles (EX load, then MEM load), then BNE resolves using mem_result forwarding disabled and rs_data.
REQ-028 SHALL pass: ALU result for $5=0x40 in MEM (mem_reg_write=1) with JR $5 in ID -> jump_taken=1, new_addr=0x10, no stall.
REQ-029 SHALL pass: J target 0x0000100 at id_pc=0x00400000 -> jump_taken=1, new_addr=0x00000100; stall and jump asserted together never appears.
REQ-030 SHALL pass: rst asserted during a stall cycle -> next cycle all outputs and counters are 0; 0x10000 consecutive stall cycles -> stall_count=0xFFFF.

Source files
------------

// File: rtl/id_redirect_unit.sv
// Decode-stage redirect unit: IF/ID pipeline register, hazard stall detection,
// branch/jump resolution with EX/MEM-to-ID operand forwarding, and event counters.
module id_redirect_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instruction,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  output logic        stall,
  output logic        branch_taken,
  output logic        jump_taken,
  output logic [31:0] branch_offset,
  output logic [31:0] new_addr,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        is_jal;
  logic        is_jr;
  logic        uses_rs;
  logic        uses_rt;
  logic        ex_any_hit;
  logic        ex_src_hit;
  logic        mem_src_hit;
  logic        fwd_rs_sel;
  logic        fwd_rt_sel;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic        operands_equal;
  logic        resolve;
  logic        redirect;
  logic        region_carry;
  logic [3:0]  jump_region;

  assign opcode  = id_instruction[31:26];
  assign funct   = id_instruction[5:0];
  assign rs_addr = id_instruction[25:21];
  assign rt_addr = id_instruction[20:16];

  assign is_beq  = (opcode == 6'b000100);
  assign is_bne  = (opcode == 6'b000101);
  assign is_j    = (opcode == 6'b000010);
  assign is_jal  = (opcode == 6'b000011);
  assign is_jr   = (opcode == 6'b000000) && (funct == 6'b001000);
  assign uses_rs = is_beq | is_bne | is_jr;
  assign uses_rt = is_beq | is_bne;

  // Load-use checks both register fields of any instruction; the branch/JR
  // checks only look at registers that instruction actually reads.
  assign ex_any_hit  = (ex_rd != 5'd0) && ((ex_rd == rs_addr) || (ex_rd == rt_addr));
  assign ex_src_hit  = (ex_rd != 5'd0) &&
                       ((uses_rs && (ex_rd == rs_addr)) || (uses_rt && (ex_rd == rt_addr)));
  assign mem_src_hit = (mem_rd != 5'd0) &&
                       ((uses_rs && (mem_rd == rs_addr)) || (uses_rt && (mem_rd == rt_addr)));

  assign stall = id_valid &&
                 ((ex_mem_read && ex_any_hit) ||
                  (ex_reg_write && ex_src_hit) ||
                  (mem_mem_read && mem_src_hit));

  // A load still in MEM has no data yet, so only ALU results are forwarded.
  assign fwd_rs_sel = mem_reg_write && !mem_mem_read && (mem_rd != 5'd0) && (mem_rd == rs_addr);
  assign fwd_rt_sel = mem_reg_write && !mem_mem_read && (mem_rd != 5'd0) && (mem_rd == rt_addr);
  assign fwd_rs     = fwd_rs_sel ? mem_result : rs_data;
  assign fwd_rt     = fwd_rt_sel ? mem_result : rt_data;
  assign operands_equal = (fwd_rs == fwd_rt);

  assign resolve      = id_valid && !stall;
  assign jump_taken   = resolve && (is_j || is_jal || is_jr);
  assign branch_taken = resolve && !jump_taken &&
                        ((is_beq && operands_equal) || (is_bne && !operands_equal));
  assign redirect     = branch_taken | jump_taken;

  assign branch_offset = {{16{id_instruction[15]}}, id_instruction[15:0]};

  // Jump region comes from PC+4, i.e. it rolls over when id_pc sits at the top of a 256MB region.
  assign region_carry = &id_pc[27:2];
  assign jump_region  = id_pc[31:28] + {3'b000, region_carry};
  assign new_addr     = is_jr ? {2'b00, fwd_rs[31:2]}
                              : {2'b00, jump_region, id_instruction[25:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc          <= 32'd0;
      id_instruction <= 32'd0;
      id_valid       <= 1'b0;
      stall_count    <= 16'd0;
      flush_count    <= 16'd0;
    end else begin
      if (stall) begin
        id_pc          <= id_pc;
        id_instruction <= id_instruction;
        id_valid       <= id_valid;
      end else if (redirect) begin
        id_pc          <= if_pc;
        id_instruction <= 32'd0;
        id_valid       <= 1'b0;
      end else begin
        id_pc          <= if_pc;
        id_instruction <= if_instruction;
        id_valid       <= 1'b1;
      end
      if (stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (redirect && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_redirect_unit.sv
// Scoreboard bench for id_redirect_unit: directed per-cycle vectors push hand-computed
// expectations into a queue that a negedge monitor pops and compares.
module tb_id_redirect_unit;

  localparam logic [31:0] BEQ_1_2_P3  = 32'h10220003;
  localparam logic [31:0] ADD_6_3_7   = 32'h00673020;
  localparam logic [31:0] BNE_4_0_M2  = 32'h1480FFFE;
  localparam logic [31:0] JR_5        = 32'h00A00008;
  localparam logic [31:0] J_100       = 32'h08000100;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        stall;
  logic        branch_taken;
  logic        jump_taken;
  logic [31:0] branch_offset;
  logic [31:0] new_addr;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_valid;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  typedef struct {
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
  } stim_t;

  typedef struct {
    string       name;
    logic        stall;
    logic        branch_taken;
    logic        jump_taken;
    logic        id_valid;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    bit          chk_id;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    bit          chk_offset;
    logic [31:0] branch_offset;
    bit          chk_addr;
    logic [31:0] new_addr;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  id_redirect_unit dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_rd         (mem_rd),
    .mem_result     (mem_result),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .jump_taken     (jump_taken),
    .branch_offset  (branch_offset),
    .new_addr       (new_addr),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .id_valid       (id_valid),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t stimIdle();
    stim_t s;
    s.rst = 1'b0;           s.if_pc = 32'd0;        s.if_instruction = 32'd0;
    s.rs_data = 32'd0;      s.rt_data = 32'd0;
    s.ex_reg_write = 1'b0;  s.ex_mem_read = 1'b0;   s.ex_rd = 5'd0;
    s.mem_reg_write = 1'b0; s.mem_mem_read = 1'b0;  s.mem_rd = 5'd0;
    s.mem_result = 32'd0;
    return s;
  endfunction

  function automatic exp_t expIdle(input string name, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.name = name;          e.stall = 1'b0;         e.branch_taken = 1'b0;
    e.jump_taken = 1'b0;    e.id_valid = 1'b0;      e.stall_count = sc;
    e.flush_count = fc;     e.chk_id = 1'b0;        e.id_pc = 32'd0;
    e.id_instruction = 32'd0; e.rs_addr = 5'd0;     e.rt_addr = 5'd0;
    e.chk_offset = 1'b0;    e.branch_offset = 32'd0;
    e.chk_addr = 1'b0;      e.new_addr = 32'd0;
    return e;
  endfunction

  function automatic exp_t withId(input exp_t ein, input logic valid, input logic [31:0] pc,
                                  input logic [31:0] instr, input logic [4:0] rs, input logic [4:0] rt);
    exp_t e = ein;
    e.chk_id = 1'b1;  e.id_valid = valid;  e.id_pc = pc;
    e.id_instruction = instr;  e.rs_addr = rs;  e.rt_addr = rt;
    return e;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue what must be seen this cycle.
  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst            = s.rst;
    if_pc          = s.if_pc;
    if_instruction = s.if_instruction;
    rs_data        = s.rs_data;
    rt_data        = s.rt_data;
    ex_reg_write   = s.ex_reg_write;
    ex_mem_read    = s.ex_mem_read;
    ex_rd          = s.ex_rd;
    mem_reg_write  = s.mem_reg_write;
    mem_mem_read   = s.mem_mem_read;
    mem_rd         = s.mem_rd;
    mem_result     = s.mem_result;
    scoreboard.push_back(e);
  endtask

  task automatic compare(input string name, input string field, input logic [31:0] act,
                         input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
    compare(e.name, "branch_taken", {31'd0, branch_taken}, {31'd0, e.branch_taken});
    compare(e.name, "jump_taken", {31'd0, jump_taken}, {31'd0, e.jump_taken});
    compare(e.name, "stall_with_redirect", {31'd0, stall & (branch_taken | jump_taken)}, 32'd0);
    compare(e.name, "id_valid", {31'd0, id_valid}, {31'd0, e.id_valid});
    compare(e.name, "stall_count", {16'd0, stall_count}, {16'd0, e.stall_count});
    compare(e.name, "flush_count", {16'd0, flush_count}, {16'd0, e.flush_count});
    if (e.chk_id) begin
      compare(e.name, "id_pc", id_pc, e.id_pc);
      compare(e.name, "id_instruction", id_instruction, e.id_instruction);
      compare(e.name, "rs_addr", {27'd0, rs_addr}, {27'd0, e.rs_addr});
      compare(e.name, "rt_addr", {27'd0, rt_addr}, {27'd0, e.rt_addr});
    end
    if (e.chk_offset) compare(e.name, "branch_offset", branch_offset, e.branch_offset);
    if (e.chk_addr) compare(e.name, "new_addr", new_addr, e.new_addr);
  endtask

  // Monitor: consumes one expectation per cycle whenever stimulus has queued one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    exp_t  e;
    rst = 1'b1;  if_pc = 32'd0;  if_instruction = 32'd0;
    rs_data = 32'd0;  rt_data = 32'd0;
    ex_reg_write = 1'b0;  ex_mem_read = 1'b0;  ex_rd = 5'd0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = 5'd0;  mem_result = 32'd0;

    s = stimIdle(); s.rst = 1'b1;
    e = withId(expIdle("reset", 16'd0, 16'd0), 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
    e.chk_offset = 1'b1; e.chk_addr = 1'b1;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h10; s.if_instruction = BEQ_1_2_P3;
    e = withId(expIdle("reset_release", 16'd0, 16'd0), 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h14; s.if_instruction = ADD_6_3_7;
    s.rs_data = 32'd5; s.rt_data = 32'd5;
    e = withId(expIdle("beq_taken", 16'd0, 16'd0), 1'b1, 32'h10, BEQ_1_2_P3, 5'd1, 5'd2);
    e.branch_taken = 1'b1; e.chk_offset = 1'b1; e.branch_offset = 32'd3;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h20; s.if_instruction = ADD_6_3_7;
    e = withId(expIdle("beq_flushed", 16'd0, 16'd1), 1'b0, 32'h14, 32'd0, 5'd0, 5'd0);
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h24; s.if_instruction = BNE_4_0_M2;
    s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_rd = 5'd3;
    e = withId(expIdle("load_use_stall", 16'd0, 16'd1), 1'b1, 32'h20, ADD_6_3_7, 5'd3, 5'd7);
    e.stall = 1'b1;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h24; s.if_instruction = BNE_4_0_M2;
    e = withId(expIdle("load_use_held", 16'd1, 16'd1), 1'b1, 32'h20, ADD_6_3_7, 5'd3, 5'd7);
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h28; s.if_instruction = ADD_6_3_7;
    s.rs_data = 32'd9; s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_rd = 5'd4;
    e = withId(expIdle("lw_branch_ex", 16'd1, 16'd1), 1'b1, 32'h24, BNE_4_0_M2, 5'd4, 5'd0);
    e.stall = 1'b1;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h28; s.if_instruction = ADD_6_3_7;
    s.rs_data = 32'd9; s.mem_reg_write = 1'b1; s.mem_mem_read = 1'b1; s.mem_rd = 5'd4;
    s.mem_result = 32'h1234;
    e = withId(expIdle("lw_branch_mem", 16'd2, 16'd1), 1'b1, 32'h24, BNE_4_0_M2, 5'd4, 5'd0);
    e.stall = 1'b1;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h28; s.if_instruction = ADD_6_3_7; s.rs_data = 32'd9;
    e = withId(expIdle("bne_taken", 16'd3, 16'd1), 1'b1, 32'h24, BNE_4_0_M2, 5'd4, 5'd0);
    e.branch_taken = 1'b1; e.chk_offset = 1'b1; e.branch_offset = 32'hFFFFFFFE;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h40; s.if_instruction = JR_5;
    e = withId(expIdle("bne_flushed", 16'd3, 16'd2), 1'b0, 32'h28, 32'd0, 5'd0, 5'd0);
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h44; s.if_instruction = ADD_6_3_7; s.rs_data = 32'h999;
    s.mem_reg_write = 1'b1; s.mem_rd = 5'd5; s.mem_result = 32'h40;
    e = withId(expIdle("jr_forward", 16'd3, 16'd2), 1'b1, 32'h40, JR_5, 5'd5, 5'd0);
    e.jump_taken = 1'b1; e.chk_addr = 1'b1; e.new_addr = 32'h10;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h00400000; s.if_instruction = J_100;
    e = withId(expIdle("jr_flushed", 16'd3, 16'd3), 1'b0, 32'h44, 32'd0, 5'd0, 5'd0);
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h00400004; s.if_instruction = BEQ_1_2_P3;
    s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_rd = 5'd0;
    e = withId(expIdle("j_target_r0", 16'd3, 16'd3), 1'b1, 32'h00400000, J_100, 5'd0, 5'd0);
    e.jump_taken = 1'b1; e.chk_addr = 1'b1; e.new_addr = 32'h00000100;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h50; s.if_instruction = BEQ_1_2_P3;
    e = withId(expIdle("j_flushed", 16'd3, 16'd4), 1'b0, 32'h00400004, 32'd0, 5'd0, 5'd0);
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h54; s.if_instruction = BEQ_1_2_P3;
    s.rs_data = 32'd7; s.rt_data = 32'd5;
    s.mem_reg_write = 1'b1; s.mem_rd = 5'd2; s.mem_result = 32'd7;
    e = withId(expIdle("beq_fwd_rt", 16'd3, 16'd4), 1'b1, 32'h50, BEQ_1_2_P3, 5'd1, 5'd2);
    e.branch_taken = 1'b1; e.chk_offset = 1'b1; e.branch_offset = 32'd3;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h58; s.if_instruction = BEQ_1_2_P3;
    e = withId(expIdle("beq_fwd_flushed", 16'd3, 16'd5), 1'b0, 32'h54, 32'd0, 5'd0, 5'd0);
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h5C; s.if_instruction = ADD_6_3_7;
    s.rs_data = 32'd1; s.rt_data = 32'd2;
    s.mem_reg_write = 1'b1; s.mem_mem_read = 1'b1; s.mem_rd = 5'd9;
    e = withId(expIdle("beq_not_taken", 16'd3, 16'd5), 1'b1, 32'h58, BEQ_1_2_P3, 5'd1, 5'd2);
    e.chk_offset = 1'b1; e.branch_offset = 32'd3;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h60; s.if_instruction = ADD_6_3_7;
    s.ex_reg_write = 1'b1; s.ex_rd = 5'd3;
    e = withId(expIdle("alu_hazard_no_stall", 16'd3, 16'd5), 1'b1, 32'h5C, ADD_6_3_7, 5'd3, 5'd7);
    applyStimulus(s, e);

    s = stimIdle(); s.rst = 1'b1; s.if_pc = 32'h64; s.if_instruction = ADD_6_3_7;
    s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_rd = 5'd3;
    e = withId(expIdle("stall_then_reset", 16'd3, 16'd5), 1'b1, 32'h60, ADD_6_3_7, 5'd3, 5'd7);
    e.stall = 1'b1;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h0; s.if_instruction = ADD_6_3_7;
    s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_rd = 5'd3;
    e = withId(expIdle("after_reset", 16'd0, 16'd0), 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
    e.chk_offset = 1'b1; e.chk_addr = 1'b1;
    applyStimulus(s, e);

    e = withId(expIdle("first_load_pc0", 16'd0, 16'd0), 1'b1, 32'd0, ADD_6_3_7, 5'd3, 5'd7);
    e.stall = 1'b1;
    applyStimulus(s, e);

    // Keep the load-use hazard pinned for 0x10000 more edges so the counter must saturate.
    repeat (32'h10000) @(posedge clk);

    e = withId(expIdle("stall_saturated", 16'hFFFF, 16'd0), 1'b1, 32'd0, ADD_6_3_7, 5'd3, 5'd7);
    e.stall = 1'b1;
    applyStimulus(s, e);

    s = stimIdle(); s.if_pc = 32'h4; s.if_instruction = ADD_6_3_7;
    e = withId(expIdle("stall_released", 16'hFFFF, 16'd0), 1'b1, 32'd0, ADD_6_3_7, 5'd3, 5'd7);
    applyStimulus(s, e);

    for (int i = 0; i < 10 && scoreboard.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (scoreboard.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", scoreboard.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
